// File: rtl/dtc_vote_pkg.sv
// -----------------------------------------------------------------------------
// dtc_vote_pkg
// Shared types and constants for the dtc_vote_* blocks.
//   CLASS_W      width of a class label produced by the tree stage
//   NUM_CLASSES  number of distinct labels (2**CLASS_W)
//   class_t      class label type
//   vote_state_t aggregator control states
// -----------------------------------------------------------------------------
package dtc_vote_pkg;

    localparam int CLASS_W     = 3;
    localparam int NUM_CLASSES = 2 ** CLASS_W;

    typedef logic [CLASS_W-1:0] class_t;

    typedef enum logic [1:0] {
        ACCUM,   // collecting labels of the current window
        REDUCE,  // sequential argmax over the counter bank
        HOLD     // result presented, waiting for the consumer
    } vote_state_t;

endpackage : dtc_vote_pkg

// File: rtl/dtc_vote_argmax.sv
// -----------------------------------------------------------------------------
// dtc_vote_argmax
// Sequential argmax over the per-class vote counters, one class per cycle.
// A start pulse arms a run; the run examines classes 0..NUM_CLASSES-1 in the
// NUM_CLASSES cycles that follow the start edge. done_o is high during the
// last of those cycles, and index_o/best_o then carry the final winner, so
// the parent can register the result on the same edge that ends the run.
// Ties keep the earlier (lower) index because only a strictly greater count
// replaces the current best.
//
// Configuration macro: DTC_VOTE_CONF_EN (adds the best_o port).
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start_i  in   pulse: begin a new run on this edge
//   cnt_i    in   counter bank, one CNT_W-bit count per class
//   index_o  out  winning class (final value while done_o=1)
//   best_o   out  winning count (final value while done_o=1), DTC_VOTE_CONF_EN only
//   done_o   out  last reduction cycle of a run
// -----------------------------------------------------------------------------
module dtc_vote_argmax
    import dtc_vote_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_i,
    output class_t                           index_o,
`ifdef DTC_VOTE_CONF_EN
    output logic [CNT_W-1:0]                 best_o,
`endif
    output logic                             done_o
);

    logic               busy_q;
    class_t             idx_q;
    class_t             best_idx_q, best_idx_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic               take;

    // Starting from (class 0, count 0) makes the first comparison a no-op
    // that leaves class 0 as the best, which is exactly "start at class 0"
    // while still reading class 0's final count after the last accept.
    always_comb begin
        take       = cnt_i[idx_q] > best_cnt_q;
        best_idx_d = take ? idx_q        : best_idx_q;
        best_cnt_d = take ? cnt_i[idx_q] : best_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; every
    // register here is small control/datapath state, so all of it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else if (busy_q) begin
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            idx_q      <= idx_q + 1'b1;
            if (idx_q == class_t'(NUM_CLASSES - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o  = busy_q && (idx_q == class_t'(NUM_CLASSES - 1));
    assign index_o = best_idx_d;
`ifdef DTC_VOTE_CONF_EN
    assign best_o  = best_cnt_d;
`endif

endmodule : dtc_vote_argmax

// File: rtl/dtc_vote_aggregator.sv
// -----------------------------------------------------------------------------
// dtc_vote_aggregator
// Tallies class labels from the decision-tree stage over windows of WIN
// samples and emits the majority class once per window over valid/ready.
// Control: ACCUM (count labels) -> REDUCE (argmax, NUM_CLASSES cycles)
// -> HOLD (present result) -> ACCUM on the output handshake.
//
// Configuration macro: DTC_VOTE_CONF_EN (adds out_conf, the winning count).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; drops any partial window
//   in_valid   in   in_class valid this cycle
//   in_ready   out  label accepted this cycle when in_valid is high
//   in_class   in   class label from the tree stage
//   out_valid  out  out_class holds a window result
//   out_ready  in   consumer takes the result
//   out_class  out  majority class of the completed window
//   out_conf   out  vote count of the winner (DTC_VOTE_CONF_EN only)
// -----------------------------------------------------------------------------
module dtc_vote_aggregator
    import dtc_vote_pkg::*;
#(
    parameter  int WIN   = 16,                 // samples per window, 1..255
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  class_t           in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output class_t           out_class
`ifdef DTC_VOTE_CONF_EN
    ,
    output logic [CNT_W-1:0] out_conf
`endif
);

    vote_state_t                       state_q;
    logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]                  sample_cnt_q, sample_cnt_d;
    logic                              out_valid_q;
    class_t                            out_class_q;

    logic   accept;
    logic   last_accept;
    logic   handshake;
    class_t am_index;
    logic   am_done;
`ifdef DTC_VOTE_CONF_EN
    logic [CNT_W-1:0] am_best;
    logic [CNT_W-1:0] out_conf_q;
`endif

    assign in_ready    = (state_q == ACCUM);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt_q == CNT_W'(WIN - 1));
    assign handshake   = out_valid_q && out_ready;

    // Counter bank. Totals never exceed WIN, so no saturation is needed.
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d        = cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (handshake) begin
            cnt_d        = '0;
            sample_cnt_d = '0;
        end else if (accept) begin
            cnt_d[in_class] = cnt_q[in_class] + CNT_W'(1);
            sample_cnt_d    = sample_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            sample_cnt_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // The argmax is started by the edge that accepts the last sample, so the
    // counters it reads from the next cycle on already include that sample.
    dtc_vote_argmax #(
        .CNT_W   (CNT_W)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .start_i (last_accept),
        .cnt_i   (cnt_q),
        .index_o (am_index),
`ifdef DTC_VOTE_CONF_EN
        .best_o  (am_best),
`endif
        .done_o  (am_done)
    );

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
`ifdef DTC_VOTE_CONF_EN
            out_conf_q  <= '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_accept) begin
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (am_done) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_class_q <= am_index;
`ifdef DTC_VOTE_CONF_EN
                        out_conf_q  <= am_best;
`endif
                    end
                end
                HOLD: begin
                    // out_class is left as-is; it is only meaningful with out_valid.
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
`ifdef DTC_VOTE_CONF_EN
    assign out_conf  = out_conf_q;
`endif

endmodule : dtc_vote_aggregator
